rx_bit_sampler: RTL
===================

Name: rx_bit_sampler

Overview:
- Oversampling front end of the UART receiver.
- Synchronises the raw serial line and tracks the oversampling edge and bit position within a frame.
- Takes three samples around each bit centre and outputs a majority-voted bit with a one-cycle valid strobe.
- Sits directly upstream of the start/parity/stop check stages. SampledBit is their sampled-bit input; SampleValid is their enable.

Parameters:
- PRESCALE_W, 6, width of Prescale and EdgeCount (supports oversampling ratios up to 32).
- FRAME_BITS, 11, bits per frame including start, data, parity, stop; BitCount wraps after FRAME_BITS-1.
- SYNC_STAGES, 2, flops in the RxIn synchroniser (min 2).

Ports:
- CLK, input, 1, receiver clock (oversampling clock).
- RST, input, 1, reset; synchronous, active-high.
- Enable, input, 1, count/sample enable from the RX FSM; low = idle.
- RxIn, input, 1, asynchronous serial line; idle level 1.
- Prescale, input, PRESCALE_W, oversampling ratio; legal values are even, 4..32.
- SampledBit, output, 1, majority-voted bit value.
- SampleValid, output, 1, one-cycle strobe: SampledBit updated this cycle.
- EdgeCount, output, PRESCALE_W, current oversampling edge within the bit, 0..Prescale-1.
- BitCount, output, 4, current bit index within the frame, 0..FRAME_BITS-1.
- RxSync, output, 1, synchronised line, used by the FSM for start-edge detection.

Behaviour:
- All flops update on the rising edge of CLK. RST is sampled on that edge.
- Reset values:
  - synchroniser flops = 1, so RxSync = 1;
  - SampledBit = 1, SampleValid = 0;
  - EdgeCount = 0, BitCount = 0;
  - sample registers s0 and s1 = 1.
- Synchroniser:
  - RxIn passes through SYNC_STAGES flops, independent of Enable.
  - Latency from RxIn to RxSync is SYNC_STAGES cycles.
- Effective prescale P:
  - P = Prescale with bit 0 forced to 0.
  - If that value is below 4, P = 4.
  - Mid point m = P/2.
- Counters (Enable=1):
  - EdgeCount increments every cycle.
  - When EdgeCount == P-1: EdgeCount goes to 0 and BitCount increments.
  - When BitCount == FRAME_BITS-1 and EdgeCount == P-1: BitCount goes to 0.
- Counters (Enable=0): EdgeCount and BitCount clear to 0 on the next edge.
- Enable is removed by the FSM; there is no internal frame-end detection.
- Sampling (only while Enable=1):
  - EdgeCount == m-1: s0 <= RxSync.
  - EdgeCount == m: s1 <= RxSync.
  - EdgeCount == m+1: SampledBit <= majority(s0, s1, RxSync) and SampleValid <= 1.
- SampleValid is high for exactly one cycle per bit, in the cycle where EdgeCount == m+2.
  - Exception: when P == 4, m+2 wraps to edge 0 of the next bit.
- Outside the strobe, SampleValid = 0. SampledBit holds its value until the next strobe.
- Enable falling mid-bit:
  - No strobe for the partial bit.
  - s0 and s1 retain their values.
  - SampledBit holds.
- Prescale change while Enable=1 is unsupported; behaviour is unspecified but must not lock up. Any wrap resumes at 0.
- Counter overflow guard: if EdgeCount is ever >= P (e.g. Prescale lowered mid-frame), the next edge wraps EdgeCount to 0 as if it were P-1.
- RST asserted mid-frame overrides Enable. All state returns to reset values on that edge; no strobe is produced in that cycle.

Decomposition:
- Shared package uart_rx_pkg:
  - PRESCALE_W and FRAME_BITS defaults;
  - IDLE_LEVEL = 1;
  - MIN_PRESCALE = 4;
  - a majority-of-3 function.
- Natural sub-module: rx_sync (parameterised N-flop synchroniser with synchronous, active-high reset to IDLE_LEVEL).
- Counters, sampling and voting stay in rx_bit_sampler.

Test Plan:
- Reset/idle: RST high 2 cycles, RxIn=1, Enable=0 -> RxSync=1, SampledBit=1, SampleValid=0, counts 0. Hold 50 cycles -> no strobe.
- Clean frame, Prescale=8:
  - Stimulus: Enable rises with edges aligned; drive bits 0,1,0,1,1,0,0,1,0,1,1, each held 8 cycles.
  - Required: 11 strobes, each when EdgeCount == 6, with SampledBit matching each bit.
  - Required: BitCount steps 0..10, then wraps to 0.
- Glitch rejection, Prescale=16 (m=8):
  - RxSync=1 for the bit except 0 at edge 7 only -> SampledBit=1.
  - RxSync=0 at edges 7 and 8 -> SampledBit=0.
- Prescale clamping: Prescale=2 -> behaves as P=4; Prescale=9 -> behaves as P=8. Samples at edges 1,2,3 and 3,4,5 respectively.
- Enable drop mid-bit, Prescale=8: Enable low at EdgeCount=4 -> no strobe, next-cycle counts 0, SampledBit unchanged.
- Reset mid-frame, Prescale=32: RST pulsed at BitCount=5, EdgeCount=17 -> next cycle all outputs at reset values. Resumed frame strobes at edge 18 of bit 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

    localparam int   DEF_PRESCALE_W = 6;
    localparam int   DEF_FRAME_BITS = 11;
    localparam logic IDLE_LEVEL     = 1'b1;
    localparam int   MIN_PRESCALE   = 4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// N-flop synchroniser for the asynchronous serial line; resets to the idle level.
module rx_sync
    import uart_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic lineRaw,
    output logic lineSync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= {STAGES{IDLE_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], lineRaw};
        end
    end

    assign lineSync = chain[STAGES-1];

endmodule

// File: rtl/rx_bit_sampler.sv
// UART receive front end: line synchroniser, edge/bit counters and
// three-sample majority vote around each bit centre.
module rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = DEF_PRESCALE_W,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic                  RxIn,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  SampledBit,
    output logic                  SampleValid,
    output logic [PRESCALE_W-1:0] EdgeCount,
    output logic [3:0]            BitCount,
    output logic                  RxSync
);

    localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] EVEN_MASK = ~ONE;
    localparam logic [PRESCALE_W-1:0] MIN_P     = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [3:0]            LAST_BIT  = 4'(FRAME_BITS - 1);

    logic [PRESCALE_W-1:0] evenPrescale;
    logic [PRESCALE_W-1:0] effPrescale;
    logic [PRESCALE_W-1:0] lastEdge;
    logic [PRESCALE_W-1:0] midPoint;
    logic                  edgeWrap;
    logic                  s0;
    logic                  s1;

    rx_sync #(
        .STAGES(SYNC_STAGES)
    ) uSync (
        .CLK      (CLK),
        .RST      (RST),
        .lineRaw  (RxIn),
        .lineSync (RxSync)
    );

    // Odd ratios round down and tiny ratios clamp up so the three sample points
    // always land inside one bit.
    assign evenPrescale = Prescale & EVEN_MASK;
    assign effPrescale  = (evenPrescale < MIN_P) ? MIN_P : evenPrescale;
    assign midPoint     = effPrescale >> 1;
    assign lastEdge     = effPrescale - ONE;
    assign edgeWrap     = (EdgeCount >= lastEdge);

    // Using >= for the wrap keeps the counter from running away if the ratio
    // shrinks mid-frame.
    always_ff @(posedge CLK) begin
        if (RST || !Enable) begin
            EdgeCount <= '0;
            BitCount  <= '0;
        end else if (edgeWrap) begin
            EdgeCount <= '0;
            BitCount  <= (BitCount >= LAST_BIT) ? 4'd0 : BitCount + 4'd1;
        end else begin
            EdgeCount <= EdgeCount + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s0          <= IDLE_LEVEL;
            s1          <= IDLE_LEVEL;
            SampledBit  <= IDLE_LEVEL;
            SampleValid <= 1'b0;
        end else begin
            SampleValid <= 1'b0;
            if (Enable) begin
                if (EdgeCount == midPoint - ONE) begin
                    s0 <= RxSync;
                end
                if (EdgeCount == midPoint) begin
                    s1 <= RxSync;
                end
                if (EdgeCount == midPoint + ONE) begin
                    SampledBit  <= majority3(s0, s1, RxSync);
                    SampleValid <= 1'b1;
                end
            end
        end
    end

endmodule
